// File: rtl/seq_divider.sv
// Sequential unsigned divider: restoring shift-subtract (one quotient bit per cycle),
// plus a single-cycle power-of-2 approximation mode and a divide-by-zero fast path.
module seq_divider #(
   parameter int unsigned DIVIDEND_WIDTH = 96,
   parameter int unsigned DIVISOR_WIDTH  = 32
) (
   input  logic                      Clock,
   input  logic                      Reset,
   input  logic                      InValid,
   output logic                      InReady,
   input  logic                      Mode,
   input  logic [DIVIDEND_WIDTH-1:0] Dividend,
   input  logic [DIVISOR_WIDTH-1:0]  Divisor,
   output logic                      OutValid,
   input  logic                      OutReady,
   output logic [DIVIDEND_WIDTH-1:0] Quotient,
   output logic [DIVISOR_WIDTH-1:0]  Remainder,
   output logic                      DivByZero
);

   localparam int unsigned DW    = DIVIDEND_WIDTH;
   localparam int unsigned VW    = DIVISOR_WIDTH;
   localparam int unsigned CNT_W = $clog2(DW + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state_q, state_d;
   logic [DW-1:0]   work_q, work_d;
   logic [VW:0]     part_q, part_d;
   logic [VW-1:0]   dvsr_q, dvsr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DW-1:0]   quot_d;
   logic [VW-1:0]   rem_d;
   logic            dbz_d;

   logic [CNT_W-1:0] msb_idx;
   logic [DW-1:0]    approx_quot;
   logic [VW-1:0]    approx_rem;
   logic [VW:0]      shifted;
   logic [VW:0]      diff;
   logic             ge;

   // Floor log2 of the incoming divisor: index of its highest set bit
   always_comb begin
      msb_idx = '0;
      for (int unsigned i = 0; i < VW; i++) begin
         if (Divisor[i]) msb_idx = CNT_W'(i);
      end
   end

   assign approx_quot = Dividend >> msb_idx;
   assign approx_rem  = VW'(Dividend & ~({DW{1'b1}} << msb_idx));

   // Partial remainder stays below the divisor, so the shifted value fits VW+1 bits
   assign shifted = (VW + 1)'({part_q, work_q[DW-1]});
   assign ge      = (shifted >= {1'b0, dvsr_q});
   assign diff    = shifted - {1'b0, dvsr_q};

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      part_d  = part_q;
      dvsr_d  = dvsr_q;
      cnt_d   = cnt_q;
      quot_d  = Quotient;
      rem_d   = Remainder;
      dbz_d   = DivByZero;
      case (state_q)
         IDLE: begin
            if (InValid) begin
               if (Divisor == '0) begin
                  quot_d  = '1;
                  rem_d   = Dividend[VW-1:0];
                  dbz_d   = 1'b1;
                  state_d = DONE;
               end else if (Mode) begin
                  quot_d  = approx_quot;
                  rem_d   = approx_rem;
                  dbz_d   = 1'b0;
                  state_d = DONE;
               end else begin
                  work_d  = Dividend;
                  part_d  = '0;
                  dvsr_d  = Divisor;
                  cnt_d   = '0;
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            // Quotient bits shift in from the LSB as dividend bits leave the MSB
            work_d = {work_q[DW-2:0], ge};
            part_d = ge ? diff : shifted;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DW - 1)) begin
               quot_d  = {work_q[DW-2:0], ge};
               rem_d   = VW'(ge ? diff : shifted);
               dbz_d   = 1'b0;
               state_d = DONE;
            end
         end
         DONE: begin
            if (OutReady) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q   <= IDLE;
         work_q    <= '0;
         part_q    <= '0;
         dvsr_q    <= '0;
         cnt_q     <= '0;
         Quotient  <= '0;
         Remainder <= '0;
         DivByZero <= 1'b0;
         InReady   <= 1'b1;
         OutValid  <= 1'b0;
      end else begin
         state_q   <= state_d;
         work_q    <= work_d;
         part_q    <= part_d;
         dvsr_q    <= dvsr_d;
         cnt_q     <= cnt_d;
         Quotient  <= quot_d;
         Remainder <= rem_d;
         DivByZero <= dbz_d;
         InReady   <= (state_d == IDLE);
         OutValid  <= (state_d == DONE);
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: arithmetic reference model checked every cycle, plus
// directed literal results and latencies.
module tb_seq_divider;

   localparam int unsigned DW = 96;
   localparam int unsigned VW = 32;

   logic          Clock = 1'b0;
   logic          Reset = 1'b0;
   logic          InValid = 1'b0;
   logic          Mode = 1'b0;
   logic          OutReady = 1'b0;
   logic [DW-1:0] Dividend = '0;
   logic [VW-1:0] Divisor = '0;
   logic          InReady, OutValid, DivByZero;
   logic [DW-1:0] Quotient;
   logic [VW-1:0] Remainder;

   int checks = 0;
   int errors = 0;

   seq_divider #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW)) dut (
      .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
      .Mode(Mode), .Dividend(Dividend), .Divisor(Divisor),
      .OutValid(OutValid), .OutReady(OutReady), .Quotient(Quotient),
      .Remainder(Remainder), .DivByZero(DivByZero)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic; fast = result appears right after the accept edge
   function automatic void calc(input logic mode, input logic [DW-1:0] dd, input logic [VW-1:0] dv,
                                output logic [DW-1:0] q, output logic [VW-1:0] r,
                                output logic z, output logic fast);
      int s;
      if (dv == '0) begin
         q = '1; r = dd[VW-1:0]; z = 1'b1; fast = 1'b1;
      end else if (mode) begin
         s = $clog2({1'b0, dv} + 33'd1) - 1;
         q = dd >> s;
         r = VW'(dd % (DW'(1) << s));
         z = 1'b0; fast = 1'b1;
      end else begin
         q = dd / DW'(dv);
         r = VW'(dd % DW'(dv));
         z = 1'b0; fast = 1'b0;
      end
   endfunction

   // Cycle-level model of the handshake and result timing
   logic          m_ready = 1'b1, m_valid = 1'b0, m_z = 1'b0, p_z;
   logic [DW-1:0] m_q = '0, p_q;
   logic [VW-1:0] m_r = '0, p_r;
   int            m_wait = 0;
   logic          p_fast;

   always @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         m_ready = 1'b1; m_valid = 1'b0; m_wait = 0;
         m_q = '0; m_r = '0; m_z = 1'b0;
      end else if (m_valid) begin
         if (OutReady) begin m_valid = 1'b0; m_ready = 1'b1; end
      end else if (m_wait > 0) begin
         m_wait--;
         if (m_wait == 0) begin m_valid = 1'b1; m_q = p_q; m_r = p_r; m_z = p_z; end
      end else if (InValid) begin
         calc(Mode, Dividend, Divisor, p_q, p_r, p_z, p_fast);
         m_ready = 1'b0;
         if (p_fast) begin m_valid = 1'b1; m_q = p_q; m_r = p_r; m_z = p_z; end
         else m_wait = DW;
      end
   end

   // Compare DUT against the model every cycle
   always @(negedge Clock) begin
      check("in_ready", DW'(InReady), DW'(m_ready));
      check("out_valid", DW'(OutValid), DW'(m_valid));
      if (m_valid || !Reset) begin
         check("quotient", Quotient, m_q);
         check("remainder", DW'(Remainder), DW'(m_r));
         check("div_by_zero", DW'(DivByZero), DW'(m_z));
      end
   end

   task automatic garbage();
      InValid  = 1'($urandom);
      Mode     = 1'($urandom);
      Dividend = {$urandom, $urandom, $urandom};
      Divisor  = $urandom;
   endtask

   task automatic do_op(input logic mode, input logic [DW-1:0] dd, input logic [VW-1:0] dv,
                        input int hold, output logic [DW-1:0] q, output logic [VW-1:0] r,
                        output logic z, output int lat);
      @(negedge Clock);
      InValid = 1'b1; Mode = mode; Dividend = dd; Divisor = dv; OutReady = 1'b0;
      @(posedge Clock); #1;
      lat = 1;
      garbage();
      while (!OutValid && lat < int'(DW) + 20) begin
         @(posedge Clock); #1;
         lat++;
         garbage();
      end
      check("op_completes", DW'(OutValid), DW'(1));
      q = Quotient; r = Remainder; z = DivByZero;
      repeat (hold) begin
         @(posedge Clock); #1;
         garbage();
      end
      if (hold > 0) begin
         check("hold_in_ready", DW'(InReady), DW'(0));
         check("hold_quotient", Quotient, q);
      end
      @(negedge Clock);
      InValid = 1'b0; OutReady = 1'b1;
      @(negedge Clock);
      OutReady = 1'b0;
      check("release_in_ready", DW'(InReady), DW'(1));
   endtask

   initial begin
      logic [DW-1:0] q, dd;
      logic [VW-1:0] r, dv;
      logic          z;
      int            lat;

      repeat (3) @(posedge Clock);
      #1;
      check("rst_in_ready", DW'(InReady), DW'(1));
      check("rst_out_valid", DW'(OutValid), DW'(0));
      check("rst_quotient", Quotient, DW'(0));
      @(posedge Clock); #2 Reset = 1'b1;

      do_op(1'b0, DW'(10), VW'(2), 0, q, r, z, lat);
      check("d10_2_q", q, DW'(5));
      check("d10_2_r", DW'(r), DW'(0));
      check("d10_2_z", DW'(z), DW'(0));
      check("d10_2_lat", DW'(lat), DW'(97));

      do_op(1'b0, DW'(97813), VW'(135), 0, q, r, z, lat);
      check("exact_q", q, DW'(724));
      check("exact_r", DW'(r), DW'(73));
      do_op(1'b1, DW'(97813), VW'(135), 0, q, r, z, lat);
      check("approx_q", q, DW'(764));
      check("approx_r", DW'(r), DW'(21));
      check("approx_lat", DW'(lat), DW'(1));

      do_op(1'b0, DW'(74101), VW'(0), 0, q, r, z, lat);
      check("dbz_q", q, {DW{1'b1}});
      check("dbz_r", DW'(r), DW'(74101));
      check("dbz_z", DW'(z), DW'(1));
      check("dbz_lat", DW'(lat), DW'(1));

      do_op(1'b0, DW'(10), VW'(2), 5, q, r, z, lat);
      check("stall_q", q, DW'(5));

      dd = {$urandom, $urandom, $urandom};
      for (int m = 0; m < 2; m++) begin
         do_op(1'(m), dd, VW'(1), 0, q, r, z, lat);
         check("div1_q", q, dd);
         check("div1_r", DW'(r), DW'(0));
      end

      // Reset in the middle of an exact division
      @(negedge Clock);
      InValid = 1'b1; Mode = 1'b0; Dividend = DW'(50); Divisor = VW'(7);
      @(posedge Clock); #1 InValid = 1'b0;
      repeat (39) @(posedge Clock);
      #2 Reset = 1'b0;
      #1;
      check("abort_out_valid", DW'(OutValid), DW'(0));
      check("abort_in_ready", DW'(InReady), DW'(1));
      check("abort_quotient", Quotient, DW'(0));
      @(posedge Clock); #2 Reset = 1'b1;
      repeat (100) @(posedge Clock);
      #1 check("abort_no_result", DW'(OutValid), DW'(0));
      do_op(1'b0, DW'(50), VW'(7), 0, q, r, z, lat);
      check("after_abort_q", q, DW'(7));
      check("after_abort_r", DW'(r), DW'(1));

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 5))
            0: dv = '0;
            1: dv = VW'(1);
            2: dv = $urandom;
            3: dv = VW'($urandom_range(1, 255));
            4: dv = VW'(1) << $urandom_range(0, VW - 1);
            default: dv = {1'b1, VW'($urandom) >> 1};
         endcase
         dd = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 1000)) : {$urandom, $urandom, $urandom};
         do_op(1'($urandom), dd, dv, $urandom_range(0, 3), q, r, z, lat);
      end

      for (int d = 1; d < 500; d++) begin
         for (int m = 0; m < 2; m++) begin
            do_op(1'(m), DW'(74101), VW'(d), 0, q, r, z, lat);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter DIVIDEND_WIDTH, default 96: dividend and quotient width.
REQ-002 SHALL have parameter DIVISOR_WIDTH, default 32: divisor and remainder width.
REQ-003 SHALL have port Clock  input  1  sole clock, rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port InValid  input  1  operand offer.
REQ-006 SHALL have port InReady  output  1  block can accept operands.
REQ-007 SHALL have port Mode  input  1  0 = exact division, 1 = power-of-2 approximation; sampled with operands.
REQ-008 SHALL have port Dividend  input  DIVIDEND_WIDTH  unsigned dividend.
REQ-009 SHALL have port Divisor  input  DIVISOR_WIDTH  unsigned divisor.
REQ-010 SHALL have port OutValid  output  1  result available.
REQ-011 SHALL have port OutReady  input  1  consumer takes result.
REQ-012 SHALL have port Quotient  output  DIVIDEND_WIDTH  unsigned quotient.
REQ-013 SHALL have port Remainder  output  DIVISOR_WIDTH  unsigned remainder.
REQ-014 SHALL have port DivByZero  output  1  result came from divisor 0.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, DONE; InReady = (state==IDLE); OutValid = (state==DONE).
REQ-016 SHALL accept operands on a rising edge with InValid&&InReady, latching Dividend, Divisor, Mode internally; inputs ignored afterwards until the next IDLE.
REQ-017 SHALL, on accept with Divisor==0, go IDLE->DONE: Quotient all ones, Remainder = Dividend[DIVISOR_WIDTH-1:0], DivByZero=1; OutValid at accept edge +1.
REQ-018 SHALL, on accept with Mode=1 and Divisor!=0, go IDLE->DONE: s = index of Divisor MSB (floor log2), Quotient = Dividend>>s, Remainder = Dividend mod 2^s; OutValid at accept edge +1.
REQ-019 SHALL, on accept with Mode=0 and Divisor!=0, enter CALC and run restoring shift-subtract, one quotient bit per cycle MSB first, for exactly DIVIDEND_WIDTH cycles; OutValid at accept edge +DIVIDEND_WIDTH+1.
REQ-020 SHALL size partial remainder DIVISOR_WIDTH+1 bits so no subtraction overflows; iteration counter ceil(log2(DIVIDEND_WIDTH+1)) bits, no wrap within one operation.
REQ-021 SHALL produce in exact mode Quotient = floor(Dividend/Divisor), Remainder = Dividend mod Divisor, bit-exact for all operands.
REQ-022 SHALL hold Quotient, Remainder, DivByZero stable throughout DONE; DONE->IDLE on edge with OutReady=1; no new accept in the same cycle (one bubble between results).
REQ-023 SHALL keep DivByZero=0 for every non-zero-divisor result.
REQ-024 SHALL support DIVISOR_WIDTH <= DIVIDEND_WIDTH; Divisor=1 returns Quotient=Dividend, Remainder=0 in both modes.

Reset
REQ-025 SHALL, while Reset=0, asynchronously force state IDLE, InReady=1, OutValid=0, Quotient=0, Remainder=0, DivByZero=0, counter=0.
REQ-026 SHALL abort any in-progress CALC or pending DONE on Reset assertion; no result emitted; first accept allowed on first edge after Reset deasserts.

Verification
REQ-027 SHALL cover: Mode=0, 10/2 -> after 97 edges OutValid=1, Quotient=5, Remainder=0, DivByZero=0.
REQ-028 SHALL cover: Mode=0, 97813/135 -> Quotient=724, Remainder=73; Mode=1, 97813/135 -> Quotient=764, Remainder=21, OutValid one edge after accept.
REQ-029 SHALL cover: Divisor=0, Dividend=74101 -> next edge OutValid=1, DivByZero=1, Quotient=all ones, Remainder=74101.
REQ-030 SHALL cover: OutReady=0 for 5 cycles in DONE -> outputs and OutValid unchanged, InReady=0; OutReady=1 -> IDLE next edge, InReady=1.
REQ-031 SHALL cover: Reset pulsed low at CALC cycle 40 of 50/7 -> all outputs reset value, no OutValid; new 50/7 then gives Quotient=7, Remainder=1.
REQ-032 SHALL cover: Dividend=74101, Divisor swept 1..499 in both modes -> exact mode matches reference floor/mod; approx mode matches Dividend>>floor(log2(Divisor)).
